// File: rtl/frame_writer.sv
`timescale 1ns/1ps
// frame_writer: draws single pixels into the next frame buffer in SRAM as
// read-modify-write of a 4-pixel word, and optionally clears the whole next
// buffer at each frame start. SRAM ownership comes from an external arbiter.
//
// Build option: define FRAME_WRITER_CLEAR_EN to compile in the frame-start
// clear engine (CLEAR state, pending-clear flag). Without it frame_start is
// ignored and clear_busy is constant 0.
module frame_writer #(
  parameter int         H_PIXELS = 640,
  parameter int         V_LINES  = 480,
  parameter logic [3:0] BG_COLOR = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        even_frame,
  input  logic        frame_start,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [3:0]  pixel_color,
  output logic        sram_req,
  input  logic        sram_gnt,
  output logic [19:0] SRAM_ADDRESS,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        clear_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3
`ifdef FRAME_WRITER_CLEAR_EN
    ,
    S_CLEAR   = 3'd4
`endif
  } state_t;

  state_t      state_reg;
  logic        buf_reg;     // buffer being written (latched ~even_frame)
  logic [9:0]  row_reg;     // pixel row, or clear row counter
  logic [7:0]  word_reg;    // word within row, or clear word counter
  logic [1:0]  nib_reg;     // nibble of the word that the pixel occupies
  logic [3:0]  color_reg;
  logic [15:0] wdata_reg;   // word to write: merged pixel word or clear pattern
  logic [15:0] merged;
  logic        pix_in_range;
  logic        pix_accept;

  // Address and write data come straight from registers; only the strobes
  // depend on the grant so the pins stay quiet while the arbiter says no.
  assign SRAM_ADDRESS = {1'b0, buf_reg, row_reg, word_reg};
  assign Data_to_SRAM = wdata_reg;
  assign sram_req     = (state_reg != S_IDLE);
  assign SRAM_OE_N    = !(sram_gnt && ((state_reg == S_RD) || (state_reg == S_RD_WAIT)));

  assign pix_in_range = (32'(pixel_x) < H_PIXELS) && (32'(pixel_y) < V_LINES);
  assign pix_accept   = pixel_valid && pixel_ready && pix_in_range;

  // Replace the addressed nibble of the word read back with the new colour.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[4*gi +: 4] = (nib_reg == 2'(gi)) ? color_reg : Data_from_SRAM[4*gi +: 4];
    end
  endgenerate

`ifdef FRAME_WRITER_CLEAR_EN
  localparam logic [7:0] WORD_LAST = 8'(H_PIXELS/4 - 1);
  localparam logic [9:0] ROW_LAST  = 10'(V_LINES - 1);

  logic pend_reg;     // frame_start seen during a pixel access
  logic start_clear;

  assign pixel_ready = (state_reg == S_IDLE) && !frame_start;
  assign SRAM_WE_N   = !(sram_gnt && ((state_reg == S_WR) || (state_reg == S_CLEAR)));
  assign clear_busy  = (state_reg == S_CLEAR) || pend_reg;

  // A clear (re)starts from IDLE or CLEAR immediately, or right after a
  // completed pixel write when a frame_start arrived during that access.
  always_comb begin
    start_clear = 1'b0;
    case (state_reg)
      S_IDLE, S_CLEAR: start_clear = frame_start;
      S_WR:            start_clear = sram_gnt && (frame_start || pend_reg);
      default:         start_clear = 1'b0;
    endcase
  end
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign pixel_ready        = (state_reg == S_IDLE);
  assign SRAM_WE_N          = !(sram_gnt && (state_reg == S_WR));
  assign clear_busy         = 1'b0;
`endif

  // Main FSM: pixel read-modify-write sequencing and the clear sweep.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_reg <= S_IDLE;
      buf_reg   <= 1'b0;
      row_reg   <= '0;
      word_reg  <= '0;
      nib_reg   <= '0;
      color_reg <= '0;
      wdata_reg <= '0;
`ifdef FRAME_WRITER_CLEAR_EN
      pend_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Out-of-range pixels are consumed here without touching SRAM.
          if (pix_accept) begin
            state_reg <= S_RD;
            buf_reg   <= ~even_frame;
            row_reg   <= pixel_y;
            word_reg  <= pixel_x[9:2];
            nib_reg   <= pixel_x[1:0];
            color_reg <= pixel_color;
          end
        end
        S_RD: begin
          if (sram_gnt) begin
            state_reg <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // Read data is valid now; a lost grant means it may be stale.
          if (sram_gnt) begin
            wdata_reg <= merged;
            state_reg <= S_WR;
          end else begin
            state_reg <= S_RD;
          end
        end
        S_WR: begin
          if (sram_gnt) begin
            state_reg <= S_IDLE;
          end else begin
            state_reg <= S_RD;
          end
        end
`ifdef FRAME_WRITER_CLEAR_EN
        S_CLEAR: begin
          if (sram_gnt) begin
            if (word_reg == WORD_LAST) begin
              word_reg <= '0;
              if (row_reg == ROW_LAST) begin
                state_reg <= S_IDLE;
              end else begin
                row_reg <= row_reg + 10'd1;
              end
            end else begin
              word_reg <= word_reg + 8'd1;
            end
          end
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
`ifdef FRAME_WRITER_CLEAR_EN
      // Clear start overrides whatever the case above chose.
      if (start_clear) begin
        state_reg <= S_CLEAR;
        buf_reg   <= ~even_frame;
        row_reg   <= '0;
        word_reg  <= '0;
        wdata_reg <= {4{BG_COLOR}};
        pend_reg  <= 1'b0;
      end else if (frame_start && ((state_reg == S_RD) || (state_reg == S_RD_WAIT) ||
                                   (state_reg == S_WR))) begin
        pend_reg <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
`timescale 1ns/1ps
// Testbench for frame_writer: table of draw requests plus hand-written
// sequences for grant loss, frame clears and reset, with an SRAM model and
// a queue of expected SRAM accesses checked as the DUT strobes the pins.
module tb_frame_writer;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        even_frame = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [3:0]  pixel_color = '0;
  logic        sram_gnt = 1'b0;
  logic        pixel_ready;
  logic        sram_req;
  logic [19:0] SRAM_ADDRESS;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        clear_busy;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  frame_writer #(
    .H_PIXELS(640),
    .V_LINES (480),
    .BG_COLOR(4'h3)
  ) dut (
    .Clk           (Clk),
    .Reset_N       (Reset_N),
    .even_frame    (even_frame),
    .frame_start   (frame_start),
    .pixel_valid   (pixel_valid),
    .pixel_ready   (pixel_ready),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_color   (pixel_color),
    .sram_req      (sram_req),
    .sram_gnt      (sram_gnt),
    .SRAM_ADDRESS  (SRAM_ADDRESS),
    .Data_to_SRAM  (Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM),
    .SRAM_WE_N     (SRAM_WE_N),
    .SRAM_OE_N     (SRAM_OE_N),
    .clear_busy    (clear_busy)
  );

  // SRAM model: write on the clock, read data valid the cycle after OE_N=0
  logic [15:0] mem [logic [19:0]];
  logic [15:0] rdata = 16'h0000;
  assign Data_from_SRAM = rdata;

  always @(posedge Clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDRESS] = Data_to_SRAM;
    if (!SRAM_OE_N) rdata <= mem.exists(SRAM_ADDRESS) ? mem[SRAM_ADDRESS] : 16'h0000;
  end

  // expected SRAM accesses, one entry per strobed cycle
  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] data;
  } txn_t;
  txn_t exp_q[$];
  txn_t mon_e;

  task automatic push(input logic we, input logic [19:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every strobed cycle must match the next expected access, and
  // the pins must be idle whenever the grant is withheld.
  always @(negedge Clk) begin
    if (Reset_N) begin
      if (!SRAM_OE_N || !SRAM_WE_N) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sram_txn: got we_n=%0b oe_n=%0b addr=%05h, expected no access",
                   SRAM_WE_N, SRAM_OE_N, SRAM_ADDRESS);
        end else begin
          mon_e = exp_q.pop_front();
          if ((SRAM_WE_N !== !mon_e.we) || (SRAM_OE_N !== mon_e.we) ||
              (SRAM_ADDRESS !== mon_e.addr) || (mon_e.we && (Data_to_SRAM !== mon_e.data))) begin
            errors++;
            $display("FAIL sram_txn: got we_n=%0b oe_n=%0b addr=%05h data=%04h, expected we=%0b addr=%05h data=%04h",
                     SRAM_WE_N, SRAM_OE_N, SRAM_ADDRESS, Data_to_SRAM,
                     mon_e.we, mon_e.addr, mon_e.data);
          end
        end
      end
      if (!sram_gnt && sram_req) begin
        checks++;
        if (!SRAM_OE_N || !SRAM_WE_N) begin
          errors++;
          $display("FAIL pins_idle_no_gnt: got we_n=%0b oe_n=%0b, expected 1 1", SRAM_WE_N, SRAM_OE_N);
        end
      end
    end
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  c;
    logic        ef;
    logic        drop;
    logic [15:0] init;
    logic [19:0] addr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[8];

  // Apply one draw request with continuous grant and check its outcome.
  task automatic draw(input vec_t v, input int idx);
    int n;
    even_frame = v.ef;
    if (!v.drop) begin
      mem[v.addr] = v.init;
      push(1'b0, v.addr, 16'h0);
      push(1'b0, v.addr, 16'h0);
      push(1'b1, v.addr, v.data);
    end
    pixel_x = v.x;
    pixel_y = v.y;
    pixel_color = v.c;
    pixel_valid = 1'b1;
    @(negedge Clk);
    check("ready_before_accept", pixel_ready, 1'b1);
    tick();
    pixel_valid = 1'b0;
    if (v.drop) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge Clk);
        check("drop_sram_req", sram_req, 1'b0);
        check("drop_ready", pixel_ready, 1'b1);
      end
    end else begin
      @(negedge Clk);
      n = 1;
      while (!pixel_ready && n < 20) begin
        @(negedge Clk);
        n++;
      end
      check("pixel_latency", n, 4);
      check("mem_word", mem[v.addr], v.data);
    end
    check("queue_drained", exp_q.size(), 0);
    $display("draw %0d x=%0d y=%0d c=%h drop=%0b addr=%05h data=%04h",
             idx, v.x, v.y, v.c, v.drop, v.addr, v.data);
    tick();
  endtask

  initial begin
    int n;

    vecs[0] = '{10'd5,    10'd2,    4'hA, 1'b0, 1'b0, 16'h1234, 20'h40201, 16'h12A4};
    vecs[1] = '{10'd0,    10'd0,    4'hF, 1'b1, 1'b0, 16'hABCD, 20'h00000, 16'hABCF};
    vecs[2] = '{10'd639,  10'd479,  4'h7, 1'b0, 1'b0, 16'h0000, 20'h5DF9F, 16'h7000};
    vecs[3] = '{10'd640,  10'd0,    4'h1, 1'b0, 1'b1, 16'h0000, 20'h00000, 16'h0000};
    vecs[4] = '{10'd10,   10'd480,  4'h2, 1'b0, 1'b1, 16'h0000, 20'h00000, 16'h0000};
    vecs[5] = '{10'd1023, 10'd1023, 4'h3, 1'b1, 1'b1, 16'h0000, 20'h00000, 16'h0000};
    vecs[6] = '{10'd2,    10'd100,  4'h5, 1'b1, 1'b0, 16'hFFFF, 20'h06400, 16'hF5FF};
    vecs[7] = '{10'd300,  10'd200,  4'hC, 1'b0, 1'b0, 16'h5A5A, 20'h4C84B, 16'h5A5C};

    // reset state
    @(posedge Clk);
    #2;
    check("rst_pixel_ready", pixel_ready, 1'b1);
    check("rst_sram_req", sram_req, 1'b0);
    check("rst_clear_busy", clear_busy, 1'b0);
    check("rst_we_n", SRAM_WE_N, 1'b1);
    check("rst_oe_n", SRAM_OE_N, 1'b1);
    check("rst_address", SRAM_ADDRESS, 20'h0);
    check("rst_data", Data_to_SRAM, 16'h0);
    tick();
    Reset_N = 1'b1;
    sram_gnt = 1'b1;
    tick();

    // table-driven draws
    for (int i = 0; i < 8; i++) draw(vecs[i], i);

    // grant withdrawn for 5 cycles while in RD_WAIT; word changes meanwhile
    even_frame = 1'b0;
    mem[20'h40201] = 16'h1234;
    push(1'b0, 20'h40201, 16'h0);
    push(1'b0, 20'h40201, 16'h0);
    push(1'b0, 20'h40201, 16'h0);
    push(1'b1, 20'h40201, 16'h5698);
    pixel_x = 10'd5;
    pixel_y = 10'd2;
    pixel_color = 4'h9;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    sram_gnt = 1'b0;
    mem[20'h40201] = 16'h5678;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("gnt_drop_oe_n", SRAM_OE_N, 1'b1);
      check("gnt_drop_we_n", SRAM_WE_N, 1'b1);
      check("gnt_drop_req", sram_req, 1'b1);
      tick();
    end
    sram_gnt = 1'b1;
    n = 0;
    while (!pixel_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("gnt_drop_done", pixel_ready, 1'b1);
    check("gnt_drop_mem", mem[20'h40201], 16'h5698);
    check("gnt_drop_queue", exp_q.size(), 0);
    $display("draw gnt_drop x=5 y=2 c=9 addr=40201 data=5698");
    tick();

`ifdef FRAME_WRITER_CLEAR_EN
    // full clear of buffer 0; a pixel offered with frame_start is refused
    even_frame = 1'b1;
    for (int r = 0; r < 480; r++)
      for (int w = 0; w < 160; w++)
        push(1'b1, {2'b00, 10'(r), 8'(w)}, 16'h3333);
    pixel_x = 10'd1;
    pixel_y = 10'd1;
    pixel_color = 4'hE;
    pixel_valid = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    check("fs_ready_low", pixel_ready, 1'b0);
    tick();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (clear_busy && n < 80000);
    check("clear_cycles", n, 76801);
    check("clear_queue", exp_q.size(), 0);
    check("clear_req_low", sram_req, 1'b0);
    check("clear_first_word", mem[20'h00000], 16'h3333);
    check("clear_last_word", mem[20'h1DF9F], 16'h3333);
    check("clear_skip_word160", mem.exists(20'h000A0), 1'b0);
    $display("clear buf=0 writes=76800 pattern=3333");
    tick();

    // frame_start during WR: pixel write completes, clear follows at once
    even_frame = 1'b0;
    mem[20'h40102] = 16'h0000;
    push(1'b0, 20'h40102, 16'h0);
    push(1'b0, 20'h40102, 16'h0);
    push(1'b1, 20'h40102, 16'h0002);
    for (int a = 0; a <= 40; a++) push(1'b1, 20'(a), 16'h3333);
    for (int a = 0; a < 10; a++) push(1'b1, 20'h40000 | 20'(a), 16'h3333);
    pixel_x = 10'd8;
    pixel_y = 10'd1;
    pixel_color = 4'h2;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    even_frame = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      check("wr_then_clear_busy", clear_busy, 1'b1);
      tick();
    end
    check("wr_then_clear_mem", mem[20'h40102], 16'h0002);
    $display("draw during_wr x=8 y=1 c=2 addr=40102 then clear buf=0");

    // frame_start during CLEAR restarts at 0,0 in the other buffer
    frame_start = 1'b1;
    even_frame = 1'b0;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      check("restart_busy", clear_busy, 1'b1);
      tick();
    end
    $display("clear restart buf=1");

    // asynchronous reset in the middle of the clear
    #2;
    Reset_N = 1'b0;
    #1;
    check("arst_pixel_ready", pixel_ready, 1'b1);
    check("arst_sram_req", sram_req, 1'b0);
    check("arst_clear_busy", clear_busy, 1'b0);
    check("arst_we_n", SRAM_WE_N, 1'b1);
    check("arst_oe_n", SRAM_OE_N, 1'b1);
    check("arst_address", SRAM_ADDRESS, 20'h0);
    check("arst_data", Data_to_SRAM, 16'h0);
    check("arst_queue", exp_q.size(), 0);
    tick();
    Reset_N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("post_rst_busy", clear_busy, 1'b0);
      check("post_rst_req", sram_req, 1'b0);
      tick();
    end
    $display("reset mid-clear");
`else
    // without the clear engine frame_start must not block or clear anything
    even_frame = 1'b0;
    mem[20'h40001] = 16'h0000;
    push(1'b0, 20'h40001, 16'h0);
    push(1'b0, 20'h40001, 16'h0);
    push(1'b1, 20'h40001, 16'h0001);
    pixel_x = 10'd4;
    pixel_y = 10'd0;
    pixel_color = 4'h1;
    pixel_valid = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    check("fs_ignored_ready", pixel_ready, 1'b1);
    check("fs_ignored_busy", clear_busy, 1'b0);
    tick();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      check("no_clear_busy", clear_busy, 1'b0);
    end while (!pixel_ready && n < 20);
    check("fs_ignored_latency", n, 4);
    check("fs_ignored_mem", mem[20'h40001], 16'h0001);
    check("fs_ignored_queue", exp_q.size(), 0);
    $display("draw with frame_start x=4 y=0 c=1 addr=40001 data=0001");
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
